ctrl_pipe_unit: RTL
===================

Name: ctrl_pipe_unit

Overview:
- Parametrised successor to the single-cycle main control decoder for the RV32 pipeline.
- Decodes the ID-stage opcode (R, I, I_LD, S, SB, plus JAL/JALR when enabled) into the control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers.
- Owns load-use hazard detection, stall/bubble insertion and branch/jump flush, which the old decoder left to an unused enable pin.
- Keeps saturating stall and flush counters for profiling.

Parameters:
- REG_W, 5, register-index width.
- JUMP_EN, 1, decode JAL (1101111) and JALR (1100111); when 0 they decode as illegal.
- HAZARD_EN, 1, instantiate load-use detection; when 0, stall_if_id is tied 0.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- hold  in  1  global freeze (memory wait); all state holds.
- enable_hazard_control  in  1  runtime enable for load-use stalling.
- id_valid  in  1  ID slot holds a real instruction.
- id_opcode  in  7  ID instruction opcode.
- id_rs1, id_rs2, id_rd  in  REG_W  ID register indices.
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle.
- stall_if_id  out  1  hold PC and IF/ID (combinational).
- flush_if_id  out  1  discard IF/ID contents (combinational).
- ex_valid, mem_valid, wb_valid  out  1  stage holds a real instruction.
- ex_ctrl, mem_ctrl, wb_ctrl  out  10  {aluop[1:0], alusrc, memtoreg, regwrite, memread, memwrite, branch, jump, illegal}.
- ex_rd, mem_rd, wb_rd  out  REG_W  destination index per stage.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Reset (async, reset_n=0): every registered output goes to 0, including all valids, ctrl, rd and counters. Reset mid-operation discards all in-flight instructions.
- Decode table {aluop, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump}:
  - R: 10_0_0_1_0_0_0_0
  - I_LD: 11_1_1_1_1_0_0_0
  - S: 11_1_0_0_0_1_0_0
  - SB: 01_0_0_0_0_0_1_0
  - I: 00_1_0_1_0_0_0_0
  - JAL: 00_0_0_1_0_0_0_1
  - JALR: 00_1_0_1_0_0_0_1
  - Any other opcode: all zero with illegal=1.
  - id_valid=0 gives an all-zero bundle.
- Operand usage:
  - rs1 is used by R, I, I_LD, S, SB, JALR.
  - rs2 is used by R, S, SB.
- Load-use condition (HAZARD_EN=1): enable_hazard_control & id_valid & ex_valid & ex_ctrl.memread & ex_rd!=0 & ((rs1 used & ex_rd==id_rs1) | (rs2 used & ex_rd==id_rs2)).
- Per-cycle priority, evaluated only when hold=0:
  1. ex_redirect=1: flush_if_id=1, stall_if_id=0. The ID/EX register loads a bubble (valid 0, ctrl 0, rd 0).
  2. Else load-use: stall_if_id=1. The ID/EX register loads a bubble; ID is not consumed.
  3. Else: the ID/EX register loads the decoded bundle, id_valid and id_rd.
- EX/MEM and MEM/WB always shift (copy the previous stage) when hold=0. Latency: a bundle decoded in cycle N appears on ex_* at N+1, mem_* at N+2, wb_* at N+3.
- hold=1: all pipeline registers and counters hold. stall_if_id and flush_if_id are forced 0, and ex_redirect is ignored; the EX source is frozen, so it is re-sampled after the hold.
- Counters:
  - stall_cnt increments by 1 on each non-held cycle where a load-use stall is taken.
  - flush_cnt increments by 1 on each non-held cycle where ex_redirect is taken.
  - Both saturate at all-ones and never wrap.
- Simultaneous redirect and load-use: redirect wins; only flush_cnt increments.
- rd==0 never triggers a stall. When id_valid=0, hazard detection is suppressed.

Test Plan:
- Reset then stream R (0110011), rd=3 -> after 1/2/3 edges, ex/mem/wb_ctrl = 10_0_0_1_0_0_0_0_0 and rd=3; all outputs are 0 during reset.
- Load with rd=5 in EX, ID=R with rs2=5, enable=1 -> stall_if_id=1 for one cycle, ex_valid=0 next cycle, then the R enters EX; stall_cnt=1. Repeat with enable=0 -> no stall.
- ID=I (addi) with rs2 field=5 after load rd=5 -> no stall, since I does not use rs2. Load rd=0 -> no stall.
- ex_redirect=1 together with a load-use hazard -> flush_if_id=1, stall_if_id=0, EX bubble, flush_cnt=1, stall_cnt=0.
- JAL with JUMP_EN=1 -> ex_ctrl jump=1 and regwrite=1. With JUMP_EN=0 -> illegal=1 and other bits 0. Opcode 0000000 -> illegal=1.
- hold=1 for 3 cycles mid-stream with a redirect asserted -> ex/mem/wb values unchanged, counters unchanged, flush_if_id=0. On release, processing resumes and the redirect is taken. Preload with CNT_W=2 and 5 stalls -> stall_cnt=3.

Source files
------------

// File: rtl/ctrl_pipe_unit.sv
// RV32 pipeline control: decode, ID/EX/MEM/WB control registers,
// load-use stall, redirect flush and saturating event counters.
module ctrl_pipe_unit #(
  parameter int REG_W     = 5,
  parameter int JUMP_EN   = 1,
  parameter int HAZARD_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hold,
  input  logic             enable_hazard_control,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_redirect,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [9:0]       ex_ctrl,
  output logic [9:0]       mem_ctrl,
  output logic [9:0]       wb_ctrl,
  output logic [REG_W-1:0] ex_rd,
  output logic [REG_W-1:0] mem_rd,
  output logic [REG_W-1:0] wb_rd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_SB   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic       is_r, is_i, is_ld, is_s, is_sb;
  logic       is_jal, is_jalr;
  logic [9:0] id_ctrl;
  logic       use_rs1, use_rs2;
  logic       load_use;
  logic       stall, flush;

  assign is_r    = id_opcode == OP_R;
  assign is_i    = id_opcode == OP_I;
  assign is_ld   = id_opcode == OP_LD;
  assign is_s    = id_opcode == OP_S;
  assign is_sb   = id_opcode == OP_SB;
  assign is_jal  = (JUMP_EN != 0) && (id_opcode == OP_JAL);
  assign is_jalr = (JUMP_EN != 0) && (id_opcode == OP_JALR);

  // Opcode to control bundle and source-operand usage
  always_comb begin
    id_ctrl = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    if (id_valid) begin
      unique case (1'b1)
        is_r: begin
          id_ctrl = 10'b10_0_0_1_0_0_0_0_0;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
        is_ld: begin
          id_ctrl = 10'b11_1_1_1_1_0_0_0_0;
          use_rs1 = 1'b1;
        end
        is_s: begin
          id_ctrl = 10'b11_1_0_0_0_1_0_0_0;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
        is_sb: begin
          id_ctrl = 10'b01_0_0_0_0_0_1_0_0;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
        is_i: begin
          id_ctrl = 10'b00_1_0_1_0_0_0_0_0;
          use_rs1 = 1'b1;
        end
        is_jal: begin
          id_ctrl = 10'b00_0_0_1_0_0_0_1_0;
        end
        is_jalr: begin
          id_ctrl = 10'b00_1_0_1_0_0_0_1_0;
          use_rs1 = 1'b1;
        end
        default: id_ctrl = 10'b00_0_0_0_0_0_0_0_1;
      endcase
    end
  end

  generate
    if (HAZARD_EN != 0) begin : g_hz
      assign load_use = enable_hazard_control
        & id_valid & ex_valid & ex_ctrl[4]
        & (ex_rd != '0)
        & ((use_rs1 & (ex_rd == id_rs1))
         | (use_rs2 & (ex_rd == id_rs2)));
    end else begin : g_nohz
      assign load_use = 1'b0;
    end
  endgenerate

  assign flush = !hold && ex_redirect;
  assign stall = !hold && !ex_redirect && load_use;

  assign stall_if_id = stall;
  assign flush_if_id = flush;

  // Advance the control pipeline; redirect or stall inject a bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_rd     <= '0;
      mem_valid <= 1'b0;
      mem_ctrl  <= '0;
      mem_rd    <= '0;
      wb_valid  <= 1'b0;
      wb_ctrl   <= '0;
      wb_rd     <= '0;
    end else if (!hold) begin
      wb_valid  <= mem_valid;
      wb_ctrl   <= mem_ctrl;
      wb_rd     <= mem_rd;
      mem_valid <= ex_valid;
      mem_ctrl  <= ex_ctrl;
      mem_rd    <= ex_rd;
      if (ex_redirect || load_use) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
        ex_rd    <= '0;
      end else begin
        ex_valid <= id_valid;
        ex_ctrl  <= id_ctrl;
        ex_rd    <= id_rd;
      end
    end
  end

  // Saturating stall/flush event counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && !(&flush_cnt))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
